// File: rtl/aud_take_ctrl_pkg.sv
// Shared types for the take controller: FSM state codes, command pulse bundle, slot base helper.
// Pure declarations; no timing or flow-control behaviour of its own.
package aud_pkg;

    localparam int SEC_W = 7;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_I2C    = 3'd1,
        S_WAIT   = 3'd2,
        S_RECD   = 3'd3,
        S_RPAUSE = 3'd4,
        S_TAKEN  = 3'd5,
        S_PLAY   = 3'd6,
        S_PPAUSE = 3'd7
    } take_state_e;

    typedef struct packed {
        logic rec_start;
        logic rec_pause;
        logic rec_stop;
        logic play_start;
        logic play_pause;
        logic play_stop;
    } cmd_t;

    // Slots are equal power-of-two sized, so a slot base is just the index in the top address bits.
    function automatic logic [31:0] take_base(input logic [31:0] sel, input int addr_w, input int tk_w);
        return sel << (addr_w - tk_w);
    endfunction

endpackage

// File: rtl/aud_take_ctrl_if.sv
// Key/status inputs and command/status outputs of the take controller.
// master = controller side, slave = surrounding recorder/DSP/key logic.
interface aud_take_ctrl_if #(
    parameter int ADDR_W    = 20,
    parameter int NUM_TAKES = 4
);
    import aud_pkg::*;

    localparam int TK_W = $clog2(NUM_TAKES);

    logic                 i_key_rec;
    logic                 i_key_stop;
    logic                 i_key_play;
    logic [TK_W-1:0]      i_take_sel;
    logic                 i_i2c_done;
    logic [ADDR_W-1:0]    i_rec_addr;
    logic [ADDR_W-1:0]    i_play_addr;
    logic                 i_play_done;

    logic                 o_i2c_start;
    logic                 o_rec_start;
    logic                 o_rec_pause;
    logic                 o_rec_stop;
    logic                 o_play_start;
    logic                 o_play_pause;
    logic                 o_play_stop;
    logic [ADDR_W-1:0]    o_take_base;
    logic [ADDR_W-1:0]    o_take_end;
    logic [NUM_TAKES-1:0] o_take_valid;
    logic [SEC_W-1:0]     o_sec;
    logic [2:0]           o_state;

    modport master (
        input  i_key_rec, i_key_stop, i_key_play, i_take_sel, i_i2c_done,
               i_rec_addr, i_play_addr, i_play_done,
        output o_i2c_start, o_rec_start, o_rec_pause, o_rec_stop,
               o_play_start, o_play_pause, o_play_stop,
               o_take_base, o_take_end, o_take_valid, o_sec, o_state
    );

    modport slave (
        output i_key_rec, i_key_stop, i_key_play, i_take_sel, i_i2c_done,
               i_rec_addr, i_play_addr, i_play_done,
        input  o_i2c_start, o_rec_start, o_rec_pause, o_rec_stop,
               o_play_start, o_play_pause, o_play_stop,
               o_take_base, o_take_end, o_take_valid, o_sec, o_state
    );

endinterface

// File: rtl/aud_take_ctrl_table.sv
// Per-slot stop-address registers plus finished-take valid vector.
// Write/clear take effect the cycle after the strobe; read is combinational; never stalls.
module aud_take_table #(
    parameter int ADDR_W    = 20,
    parameter int NUM_TAKES = 4,
    parameter int TK_W      = $clog2(NUM_TAKES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic                 clr,
    input  logic [TK_W-1:0]      wr_idx,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [TK_W-1:0]      rd_idx,
    output logic [ADDR_W-1:0]    rd_addr,
    output logic [NUM_TAKES-1:0] valid
);

    logic [ADDR_W-1:0] end_q [NUM_TAKES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_TAKES; i++) end_q[i] <= '0;
            valid <= '0;
        end else if (wr_en) begin
            end_q[wr_idx] <= wr_addr;
            valid[wr_idx] <= 1'b1;
        end else if (clr) begin
            valid[wr_idx] <= 1'b0;
        end
    end

    assign rd_addr = end_q[rd_idx];

endmodule

// File: rtl/aud_take_ctrl.sv
// Record/play session FSM over NUM_TAKES SRAM slots; command pulses one cycle after the key.
// No backpressure: keys are pulses, illegal ones dropped. `AUD_LOOP_PLAY_EN makes play_done restart playback.
module aud_take_ctrl
    import aud_pkg::*;
#(
    parameter int ADDR_W    = 20,
    parameter int NUM_TAKES = 4,
    parameter int SEC_SHIFT = 15
) (
    input  logic           i_clk,
    input  logic           i_rst,
    aud_take_ctrl_if.master bus
);

    localparam int TK_W    = $clog2(NUM_TAKES);
    localparam int SLOT_W  = ADDR_W - TK_W;
    localparam int SEC_MAX = (1 << SEC_W) - 1;

    take_state_e          state, state_nxt;
    cmd_t                 cmd_q, cmd_nxt;
    logic [TK_W-1:0]      slot;
    logic                 slot_ld;
    logic                 tbl_wr, tbl_clr;
    logic [TK_W-1:0]      tbl_idx;
    logic [ADDR_W-1:0]    end_rd;
    logic [NUM_TAKES-1:0] valid;
    logic [ADDR_W-1:0]    base, last;
    logic [ADDR_W-1:0]    act_addr, offset;
    logic                 act_en;
    logic [SEC_W-1:0]     sec;

    assign base = ADDR_W'(take_base(32'(slot), ADDR_W, TK_W));
    assign last = base | {{TK_W{1'b0}}, {SLOT_W{1'b1}}};

    aud_take_table #(
        .ADDR_W    (ADDR_W),
        .NUM_TAKES (NUM_TAKES),
        .TK_W      (TK_W)
    ) u_table (
        .clk     (i_clk),
        .rst     (i_rst),
        .wr_en   (tbl_wr),
        .clr     (tbl_clr),
        .wr_idx  (tbl_idx),
        .wr_addr (bus.i_rec_addr),
        .rd_idx  (slot),
        .rd_addr (end_rd),
        .valid   (valid)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
            cmd_q <= '0;
            slot  <= '0;
        end else begin
            state <= state_nxt;
            cmd_q <= cmd_nxt;
            if (slot_ld) slot <= bus.i_take_sel;
        end
    end

    // Within each state the branch order encodes stop/full/done > rec > play.
    always_comb begin
        state_nxt = state;
        cmd_nxt   = '0;
        slot_ld   = 1'b0;
        tbl_wr    = 1'b0;
        tbl_clr   = 1'b0;
        tbl_idx   = slot;
        case (state)
            S_IDLE: state_nxt = S_I2C;
            S_I2C: if (bus.i_i2c_done) state_nxt = S_WAIT;
            S_WAIT, S_TAKEN: begin
                if (bus.i_key_rec) begin
                    slot_ld           = 1'b1;
                    tbl_clr           = 1'b1;
                    tbl_idx           = bus.i_take_sel;
                    cmd_nxt.rec_start = 1'b1;
                    state_nxt         = S_RECD;
                end else if (state == S_TAKEN && bus.i_key_play) begin
                    slot_ld = 1'b1;
                    if (valid[bus.i_take_sel]) begin
                        cmd_nxt.play_start = 1'b1;
                        state_nxt          = S_PLAY;
                    end
                end
            end
            S_RECD, S_RPAUSE: begin
                if (bus.i_key_stop || bus.i_rec_addr == last) begin
                    tbl_wr           = 1'b1;
                    cmd_nxt.rec_stop = 1'b1;
                    state_nxt        = S_TAKEN;
                end else if (bus.i_key_rec) begin
                    cmd_nxt.rec_pause = 1'b1;
                    state_nxt         = (state == S_RECD) ? S_RPAUSE : S_RECD;
                end
            end
            S_PLAY: begin
                if (bus.i_key_stop) begin
                    cmd_nxt.play_stop = 1'b1;
                    state_nxt         = S_TAKEN;
                end else if (bus.i_play_done) begin
`ifdef AUD_LOOP_PLAY_EN
                    cmd_nxt.play_start = 1'b1;
`else
                    cmd_nxt.play_stop  = 1'b1;
                    state_nxt          = S_TAKEN;
`endif
                end else if (bus.i_key_play) begin
                    cmd_nxt.play_pause = 1'b1;
                    state_nxt          = S_PPAUSE;
                end
            end
            S_PPAUSE: begin
                if (bus.i_key_stop) begin
                    cmd_nxt.play_stop = 1'b1;
                    state_nxt         = S_TAKEN;
                end else if (bus.i_key_play) begin
                    cmd_nxt.play_pause = 1'b1;
                    state_nxt          = S_PLAY;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        act_addr = '0;
        act_en   = 1'b0;
        case (state)
            S_RECD, S_RPAUSE: begin act_addr = bus.i_rec_addr;  act_en = 1'b1; end
            S_PLAY, S_PPAUSE: begin act_addr = bus.i_play_addr; act_en = 1'b1; end
            default: ;
        endcase
        offset = (act_addr - base) >> SEC_SHIFT;
        if (!act_en)                        sec = '0;
        else if (offset > ADDR_W'(SEC_MAX)) sec = SEC_W'(SEC_MAX);
        else                                sec = offset[SEC_W-1:0];
    end

    assign bus.o_i2c_start  = (state == S_I2C);
    assign bus.o_rec_start  = cmd_q.rec_start;
    assign bus.o_rec_pause  = cmd_q.rec_pause;
    assign bus.o_rec_stop   = cmd_q.rec_stop;
    assign bus.o_play_start = cmd_q.play_start;
    assign bus.o_play_pause = cmd_q.play_pause;
    assign bus.o_play_stop  = cmd_q.play_stop;
    assign bus.o_take_base  = base;
    assign bus.o_take_end   = end_rd;
    assign bus.o_take_valid = valid;
    assign bus.o_sec        = sec;
    assign bus.o_state      = state;

endmodule

// File: tb/tb_aud_take_ctrl.sv
// Directed vector bench for aud_take_ctrl; expectations follow AUD_LOOP_PLAY_EN when defined.
module tb_aud_take_ctrl;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_I2C = 3'd1, ST_WAIT = 3'd2, ST_RECD = 3'd3,
                           ST_RPAU = 3'd4, ST_TAKEN = 3'd5, ST_PLAY = 3'd6, ST_PPAU = 3'd7;
    // pulse field order: {i2c_start, rec_start, rec_pause, rec_stop, play_start, play_pause, play_stop}
    localparam logic [6:0] P_NONE = 7'b0000000, P_I2C = 7'b1000000, P_RS = 7'b0100000,
                           P_RP = 7'b0010000, P_RX = 7'b0001000, P_PS = 7'b0000100,
                           P_PP = 7'b0000010, P_PX = 7'b0000001;

    typedef struct packed {
        logic        rst, done, krec, kstop, kplay;
        logic [1:0]  sel;
        logic [19:0] ra, pa;
        logic        pdone;
    } in_t;

    typedef struct packed {
        logic [2:0]  st;
        logic [6:0]  pulses;
        logic [19:0] base, tend;
        logic [3:0]  vld;
        logic [6:0]  sec;
    } out_t;

    typedef struct { in_t i; out_t o; } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    aud_take_ctrl_if #(.ADDR_W(20), .NUM_TAKES(4)) bus ();

    aud_take_ctrl #(.ADDR_W(20), .NUM_TAKES(4), .SEC_SHIFT(15)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    function automatic in_t mk_in(logic r, logic d, logic kr, logic ks, logic kp,
                                  logic [1:0] s, logic [19:0] ra, logic [19:0] pa, logic pd);
        in_t v;
        v = '{rst: r, done: d, krec: kr, kstop: ks, kplay: kp, sel: s, ra: ra, pa: pa, pdone: pd};
        return v;
    endfunction

    function automatic out_t mk_out(logic [2:0] st, logic [6:0] p, logic [19:0] b,
                                    logic [19:0] e, logic [3:0] v, logic [6:0] s);
        out_t o;
        o = '{st: st, pulses: p, base: b, tend: e, vld: v, sec: s};
        return o;
    endfunction

    task automatic add(input in_t i, input out_t o);
        vec_t v;
        v.i = i;
        v.o = o;
        vq.push_back(v);
    endtask

    task automatic drive(input in_t i);
        rst             = i.rst;
        bus.i_i2c_done  = i.done;
        bus.i_key_rec   = i.krec;
        bus.i_key_stop  = i.kstop;
        bus.i_key_play  = i.kplay;
        bus.i_take_sel  = i.sel;
        bus.i_rec_addr  = i.ra;
        bus.i_play_addr = i.pa;
        bus.i_play_done = i.pdone;
    endtask

    function automatic out_t sample();
        out_t o;
        o.st     = bus.o_state;
        o.pulses = {bus.o_i2c_start, bus.o_rec_start, bus.o_rec_pause, bus.o_rec_stop,
                    bus.o_play_start, bus.o_play_pause, bus.o_play_stop};
        o.base   = bus.o_take_base;
        o.tend   = bus.o_take_end;
        o.vld    = bus.o_take_valid;
        o.sec    = bus.o_sec;
        return o;
    endfunction

    initial begin
        int   hi;
        logic reached;
        out_t act;

        // I2C bring-up with done already high: i2c_start must last exactly one cycle.
        drive(mk_in(1, 1, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        hi = 0;
        reached = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (bus.o_i2c_start) hi++;
            if (bus.o_state == ST_WAIT) begin
                reached = 1'b1;
                break;
            end
        end
        total++;
        if (!reached) begin
            bad++;
            $display("FAIL i2c_reach_wait: state=%0d never reached %0d within 10 cycles", bus.o_state, ST_WAIT);
        end
        total++;
        if (hi != 1) begin
            bad++;
            $display("FAIL i2c_start_width: high for %0d cycles, need 1", hi);
        end

        //        rst done krec kstop kplay sel ra        pa        pdone
        add(mk_in(1, 0, 0, 0, 0, 0, 20'h0,     20'h0,     0), mk_out(ST_IDLE,  P_NONE, 20'h0,     20'h0,     4'b0000, 0));
        add(mk_in(1, 0, 0, 0, 0, 0, 20'h0,     20'h0,     0), mk_out(ST_IDLE,  P_NONE, 20'h0,     20'h0,     4'b0000, 0));
        add(mk_in(0, 0, 0, 0, 0, 0, 20'h0,     20'h0,     0), mk_out(ST_I2C,   P_I2C,  20'h0,     20'h0,     4'b0000, 0));
        add(mk_in(0, 0, 0, 0, 0, 0, 20'h0,     20'h0,     0), mk_out(ST_I2C,   P_I2C,  20'h0,     20'h0,     4'b0000, 0));
        add(mk_in(0, 1, 0, 0, 0, 0, 20'h0,     20'h0,     0), mk_out(ST_WAIT,  P_NONE, 20'h0,     20'h0,     4'b0000, 0));
        add(mk_in(0, 1, 1, 0, 0, 2, 20'h80000, 20'h0,     0), mk_out(ST_RECD,  P_RS,   20'h80000, 20'h0,     4'b0000, 0));
        add(mk_in(0, 1, 0, 0, 0, 0, 20'h88000, 20'h0,     0), mk_out(ST_RECD,  P_NONE, 20'h80000, 20'h0,     4'b0000, 1));
        add(mk_in(0, 1, 1, 0, 0, 0, 20'h88000, 20'h0,     0), mk_out(ST_RPAU,  P_RP,   20'h80000, 20'h0,     4'b0000, 1));
        add(mk_in(0, 1, 1, 0, 1, 0, 20'h88000, 20'h0,     0), mk_out(ST_RECD,  P_RP,   20'h80000, 20'h0,     4'b0000, 1));
        add(mk_in(0, 1, 0, 1, 0, 0, 20'h80100, 20'h0,     0), mk_out(ST_TAKEN, P_RX,   20'h80000, 20'h80100, 4'b0100, 0));
        add(mk_in(0, 1, 1, 0, 0, 1, 20'h40000, 20'h0,     0), mk_out(ST_RECD,  P_RS,   20'h40000, 20'h0,     4'b0100, 0));
        add(mk_in(0, 1, 0, 0, 0, 1, 20'h7FFFE, 20'h0,     0), mk_out(ST_RECD,  P_NONE, 20'h40000, 20'h0,     4'b0100, 7));
        add(mk_in(0, 1, 0, 0, 0, 1, 20'h7FFFF, 20'h0,     0), mk_out(ST_TAKEN, P_RX,   20'h40000, 20'h7FFFF, 4'b0110, 0));
        add(mk_in(0, 1, 1, 0, 0, 2, 20'h80000, 20'h0,     0), mk_out(ST_RECD,  P_RS,   20'h80000, 20'h80100, 4'b0010, 0));
        add(mk_in(0, 1, 0, 1, 0, 2, 20'h80100, 20'h0,     0), mk_out(ST_TAKEN, P_RX,   20'h80000, 20'h80100, 4'b0110, 0));
        add(mk_in(0, 1, 0, 0, 1, 3, 20'h80100, 20'h0,     0), mk_out(ST_TAKEN, P_NONE, 20'hC0000, 20'h0,     4'b0110, 0));
        add(mk_in(0, 1, 0, 0, 1, 2, 20'h0,     20'h80000, 0), mk_out(ST_PLAY,  P_PS,   20'h80000, 20'h80100, 4'b0110, 0));
        add(mk_in(0, 1, 0, 0, 0, 0, 20'h0,     20'h90000, 0), mk_out(ST_PLAY,  P_NONE, 20'h80000, 20'h80100, 4'b0110, 2));
        add(mk_in(0, 1, 0, 0, 1, 0, 20'h0,     20'h90000, 0), mk_out(ST_PPAU,  P_PP,   20'h80000, 20'h80100, 4'b0110, 2));
        add(mk_in(0, 1, 0, 0, 0, 0, 20'h0,     20'h90000, 1), mk_out(ST_PPAU,  P_NONE, 20'h80000, 20'h80100, 4'b0110, 2));
        add(mk_in(0, 1, 0, 0, 1, 0, 20'h0,     20'h90000, 0), mk_out(ST_PLAY,  P_PP,   20'h80000, 20'h80100, 4'b0110, 2));
        add(mk_in(0, 1, 0, 1, 1, 0, 20'h0,     20'h90000, 0), mk_out(ST_TAKEN, P_PX,   20'h80000, 20'h80100, 4'b0110, 0));
        add(mk_in(0, 1, 0, 0, 1, 2, 20'h0,     20'h80000, 0), mk_out(ST_PLAY,  P_PS,   20'h80000, 20'h80100, 4'b0110, 0));
`ifdef AUD_LOOP_PLAY_EN
        add(mk_in(0, 1, 0, 0, 0, 2, 20'h0,     20'h80100, 1), mk_out(ST_PLAY,  P_PS,   20'h80000, 20'h80100, 4'b0110, 0));
        add(mk_in(0, 1, 0, 1, 0, 2, 20'h0,     20'h80100, 0), mk_out(ST_TAKEN, P_PX,   20'h80000, 20'h80100, 4'b0110, 0));
`else
        add(mk_in(0, 1, 0, 0, 0, 2, 20'h0,     20'h80100, 1), mk_out(ST_TAKEN, P_PX,   20'h80000, 20'h80100, 4'b0110, 0));
        add(mk_in(0, 1, 0, 1, 0, 2, 20'h0,     20'h80100, 0), mk_out(ST_TAKEN, P_NONE, 20'h80000, 20'h80100, 4'b0110, 0));
`endif
        add(mk_in(0, 1, 0, 0, 1, 2, 20'h0,     20'h80000, 0), mk_out(ST_PLAY,  P_PS,   20'h80000, 20'h80100, 4'b0110, 0));
        add(mk_in(0, 1, 0, 0, 0, 2, 20'h0,     20'h98000, 0), mk_out(ST_PLAY,  P_NONE, 20'h80000, 20'h80100, 4'b0110, 3));
        add(mk_in(1, 1, 0, 0, 1, 2, 20'h0,     20'h98000, 0), mk_out(ST_IDLE,  P_NONE, 20'h0,     20'h0,     4'b0000, 0));
        add(mk_in(0, 0, 1, 0, 0, 0, 20'h0,     20'h0,     0), mk_out(ST_I2C,   P_I2C,  20'h0,     20'h0,     4'b0000, 0));
        add(mk_in(0, 1, 0, 0, 0, 0, 20'h0,     20'h0,     0), mk_out(ST_WAIT,  P_NONE, 20'h0,     20'h0,     4'b0000, 0));
        add(mk_in(0, 1, 1, 1, 1, 3, 20'hC0000, 20'h0,     0), mk_out(ST_RECD,  P_RS,   20'hC0000, 20'h0,     4'b0000, 0));
        add(mk_in(0, 1, 0, 1, 0, 3, 20'hC0010, 20'h0,     0), mk_out(ST_TAKEN, P_RX,   20'hC0000, 20'hC0010, 4'b1000, 0));
        add(mk_in(0, 1, 1, 0, 1, 1, 20'h40000, 20'h0,     0), mk_out(ST_RECD,  P_RS,   20'h40000, 20'h0,     4'b1000, 0));
        add(mk_in(0, 1, 1, 1, 0, 1, 20'h40020, 20'h0,     0), mk_out(ST_TAKEN, P_RX,   20'h40000, 20'h40020, 4'b1010, 0));
        add(mk_in(0, 1, 0, 0, 1, 1, 20'h0,     20'h40000, 0), mk_out(ST_PLAY,  P_PS,   20'h40000, 20'h40020, 4'b1010, 0));
`ifdef AUD_LOOP_PLAY_EN
        add(mk_in(0, 1, 0, 0, 1, 1, 20'h0,     20'h40000, 1), mk_out(ST_PLAY,  P_PS,   20'h40000, 20'h40020, 4'b1010, 0));
`else
        add(mk_in(0, 1, 0, 0, 1, 1, 20'h0,     20'h40000, 1), mk_out(ST_TAKEN, P_PX,   20'h40000, 20'h40020, 4'b1010, 0));
`endif

        foreach (vq[n]) begin
            drive(vq[n].i);
            @(posedge clk);
            #1;
            act = sample();
            total++;
            if (act !== vq[n].o) begin
                bad++;
                $display("FAIL vec%0d: got st=%0d pulses=%b base=%h end=%h vld=%b sec=%0d, want st=%0d pulses=%b base=%h end=%h vld=%b sec=%0d",
                         n, act.st, act.pulses, act.base, act.tend, act.vld, act.sec,
                         vq[n].o.st, vq[n].o.pulses, vq[n].o.base, vq[n].o.tend, vq[n].o.vld, vq[n].o.sec);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
